// File: rtl/reg_file.sv
// rtl/reg_file.sv - DEPTH x WIDTH register file with load/increment/clear and two read ports.
// Optional write-first forwarding to the read ports: define REG_FILE_BYPASS_EN.
module reg_file #(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [WIDTH-1:0]  in_i,
   input  logic              load_i,
   input  logic              inc_i,
   input  logic              clr_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [ADDR_W-1:0] raddr_a_i,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic [WIDTH-1:0]  out_a_o,
   output logic [WIDTH-1:0]  out_b_o,
   output logic              valid_a_o,
   output logic              valid_b_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] wdata;
   logic             wr_en;
   logic             wipe;

   // Load wins over increment when both are asserted.
   assign wipe  = rst_i | clr_i;
   assign wr_en = (load_i | inc_i) & ~wipe;
   assign wdata = load_i ? in_i : mem[waddr_i] + WIDTH'(1);

   always_ff @(posedge clk_i) begin
      if (wipe) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         vld <= '0;
      end else if (wr_en) begin
         mem[waddr_i] <= wdata;
         vld[waddr_i] <= 1'b1;
      end
   end

`ifdef REG_FILE_BYPASS_EN
   // Reads observe the value this edge will commit.
   always_comb begin
      out_a_o   = mem[raddr_a_i];
      valid_a_o = vld[raddr_a_i];
      if (wipe) begin
         out_a_o   = '0;
         valid_a_o = 1'b0;
      end else if (wr_en && raddr_a_i == waddr_i) begin
         out_a_o   = wdata;
         valid_a_o = 1'b1;
      end
   end

   always_comb begin
      out_b_o   = mem[raddr_b_i];
      valid_b_o = vld[raddr_b_i];
      if (wipe) begin
         out_b_o   = '0;
         valid_b_o = 1'b0;
      end else if (wr_en && raddr_b_i == waddr_i) begin
         out_b_o   = wdata;
         valid_b_o = 1'b1;
      end
   end
`else
   always_comb begin
      out_a_o   = mem[raddr_a_i];
      valid_a_o = vld[raddr_a_i];
      out_b_o   = mem[raddr_b_i];
      valid_b_o = vld[raddr_b_i];
   end
`endif

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 16, data bits per entry (>=1).
REQ-002 Parameter DEPTH, default 8, entry count; power of two, >=2; ADDR_W = log2(DEPTH) is derived locally, not overridable.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 in_i  input  WIDTH  write data.
REQ-006 load_i  input  1  write in_i into entry waddr_i.
REQ-007 inc_i  input  1  increment entry waddr_i by 1.
REQ-008 clr_i  input  1  synchronous clear of all entries.
REQ-009 waddr_i  input  ADDR_W  write/increment address.
REQ-010 raddr_a_i  input  ADDR_W  read port A address.
REQ-011 raddr_b_i  input  ADDR_W  read port B address.
REQ-012 out_a_o  output  WIDTH  entry raddr_a_i contents.
REQ-013 out_b_o  output  WIDTH  entry raddr_b_i contents.
REQ-014 valid_a_o  output  1  entry raddr_a_i written/incremented since last reset/clear.
REQ-015 valid_b_o  output  1  same, for raddr_b_i.

Function
REQ-016 Storage: DEPTH x WIDTH data array plus DEPTH valid flags, all flops.
REQ-017 Reads combinational, zero latency; both ports independent; raddr_a_i == raddr_b_i legal, outputs identical.
REQ-018 Per-edge priority: rst_i > clr_i > load_i > inc_i > hold.
REQ-019 load_i=1: entry[waddr_i] <= in_i, valid[waddr_i] <= 1; visible on reads from the next cycle.
REQ-020 inc_i=1, load_i=0: entry[waddr_i] <= entry[waddr_i] + 1 modulo 2^WIDTH; all-ones wraps to 0; valid[waddr_i] <= 1.
REQ-021 inc on an invalid entry: 0 -> 1, valid set.
REQ-022 load_i and inc_i both 1: load only; no increment applied.
REQ-023 clr_i=1: all entries and valid flags <= 0; concurrent load_i/inc_i ignored.
REQ-024 Only entry waddr_i changes on any write/increment; all other entries hold.
REQ-025 No operation stalls; every cycle accepts a new command.

Reset
REQ-026 rst_i sampled at rising edge: all entries <= 0, all valid flags <= 0, regardless of other inputs.
REQ-027 After reset, out_a_o/out_b_o = 0 and valid_a_o/valid_b_o = 0 for all addresses until a write.
REQ-028 Reset asserted while a write is presented: write discarded.
REQ-029 Multi-cycle reset: state held at 0 throughout; first write accepted on the first edge with rst_i=0.

Configuration
REQ-030 Macro REG_FILE_BYPASS_EN, when defined: read port with raddr == waddr_i and load_i=1, rst_i=0, clr_i=0 returns in_i (valid=1) combinationally in the same cycle (write-first).
REQ-031 REG_FILE_BYPASS_EN defined: same-cycle increment forwards entry+1 (valid=1); clr_i forwards 0 (valid=0).
REQ-032 REG_FILE_BYPASS_EN undefined: reads always return stored state (read-first); new value appears the cycle after the edge.

Verification
REQ-033 Reset, then read all 8 addresses -> out=0x0000, valid=0 on both ports.
REQ-034 load 0x1234 @addr3, next cycle raddr_a=3, raddr_b=2 -> out_a=0x1234 valid_a=1; out_b=0x0000 valid_b=0.
REQ-035 load 0xFFFF @addr5, then inc @addr5 -> 0x0000 valid=1; second inc -> 0x0001.
REQ-036 load 0xAAAA and inc together @addr1 -> 0xAAAA; then clr_i with load 0x5555 @addr1 -> all entries 0, valid=0.
REQ-037 load 0xBEEF @addr7, raddr_a=7 same cycle -> out_a=0xBEEF with REG_FILE_BYPASS_EN, prior value 0x0000 without; both 0xBEEF next cycle.
REQ-038 rst_i high with load 0x00FF @addr0 -> addr0=0x0000, valid=0 after edge.
